// File: rtl/cpu_pkg.sv
// Shared types for the 16-bit ALU datapath: widths, writeback FSM states
// and the queued writeback entry.
package cpu_pkg;

    localparam int DATA_W = 16;
    localparam int REG_AW = 4;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        HOLD
    } state_t;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/cpu_wb_fifo.sv
// In-order writeback queue. Exposes every slot ordered oldest-to-youngest so
// the register file can forward from the youngest matching entry.
module cpu_wb_fifo
    import cpu_pkg::*;
#(
    parameter int QDEPTH = 4,
    localparam int PW = $clog2(QDEPTH),
    localparam int CW = PW + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  wb_entry_t         push_entry,
    input  logic              pop,
    input  logic              flush,
    output logic [CW-1:0]     count,
    output wb_entry_t         head_entry,
    output logic [QDEPTH-1:0] age_valid,
    output wb_entry_t         age_entry [QDEPTH]
);

    wb_entry_t         mem_reg [QDEPTH];
    logic [PW-1:0]     head_reg;
    logic [PW-1:0]     tail_reg;
    logic [CW-1:0]     count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else if (flush) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push) begin
                tail_reg <= tail_reg + PW'(1);
            end
            if (pop) begin
                head_reg <= head_reg + PW'(1);
            end
            count_reg <= count_reg + CW'(push) - CW'(pop);
        end
    end

    // Payload storage carries no reset; slot validity comes from count_reg.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg[tail_reg] <= push_entry;
        end
    end

    assign count      = count_reg;
    assign head_entry = mem_reg[head_reg];

    for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_age
        logic [PW-1:0] idx;
        assign idx           = head_reg + PW'(gi);
        assign age_valid[gi] = (CW'(gi) < count_reg);
        assign age_entry[gi] = mem_reg[idx];
    end

endmodule

// File: rtl/cpu_wb_regfile.sv
// Writeback stage: queues tagged ALU results, retires one per cycle into the
// architectural register file and forwards queued values to two read ports.
module cpu_wb_regfile #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int NREGS  = 16,
    parameter int QDEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wb_valid,
    output logic                      wb_ready,
    input  logic [3:0]                wb_rd,
    input  logic [DATA_W-1:0]         wb_data,
    input  logic                      wb_stall,
    input  logic                      flush,
    input  logic [3:0]                rd_addr1,
    input  logic [3:0]                rd_addr2,
    output logic [DATA_W-1:0]         rd_data1,
    output logic [DATA_W-1:0]         rd_data2,
    output logic [$clog2(QDEPTH):0]   q_count,
    output logic                      busy,
    output logic [15:0]               retired_cnt
);

    localparam int CW = $clog2(QDEPTH) + 1;

    cpu_pkg::wb_entry_t push_entry;
    cpu_pkg::wb_entry_t head_entry;
    cpu_pkg::wb_entry_t age_entry [QDEPTH];
    logic [QDEPTH-1:0]  age_valid;
    logic [CW-1:0]      count;
    logic [CW-1:0]      count_next;
    logic               accept;
    logic               retire;
    cpu_pkg::state_t    state_reg;
    logic [DATA_W-1:0]  regs_reg [NREGS];
    logic [15:0]        retired_cnt_reg;

    assign push_entry = {wb_rd, wb_data};
    assign wb_ready   = (count < CW'(QDEPTH)) && !flush;
    assign accept     = wb_valid && wb_ready;
    assign retire     = (count != '0) && !wb_stall && !flush;
    assign count_next = flush ? '0 : (count + CW'(accept) - CW'(retire));

    cpu_wb_fifo #(
        .QDEPTH(QDEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (accept),
        .push_entry(push_entry),
        .pop       (retire),
        .flush     (flush),
        .count     (count),
        .head_entry(head_entry),
        .age_valid (age_valid),
        .age_entry (age_entry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_reg[r] <= '0;
            end
            retired_cnt_reg <= '0;
        end else if (retire) begin
            regs_reg[head_entry.rd] <= head_entry.data;
            retired_cnt_reg         <= retired_cnt_reg + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= cpu_pkg::IDLE;
        end else begin
            case (state_reg)
                cpu_pkg::IDLE: begin
                    if (accept) state_reg <= cpu_pkg::DRAIN;
                end
                cpu_pkg::DRAIN, cpu_pkg::HOLD: begin
                    if (flush || count_next == '0) state_reg <= cpu_pkg::IDLE;
                    else if (wb_stall)              state_reg <= cpu_pkg::HOLD;
                    else                            state_reg <= cpu_pkg::DRAIN;
                end
                default: state_reg <= cpu_pkg::IDLE;
            endcase
        end
    end

    // Later (younger) matching slots override earlier ones.
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
        logic [3:0]        addr;
        logic [DATA_W-1:0] data_fwd;
        assign addr = (gi == 0) ? rd_addr1 : rd_addr2;
        always_comb begin
            data_fwd = regs_reg[addr];
            for (int k = 0; k < QDEPTH; k++) begin
                if (age_valid[k] && age_entry[k].rd == addr) begin
                    data_fwd = age_entry[k].data;
                end
            end
        end
    end

    assign rd_data1    = g_rd[0].data_fwd;
    assign rd_data2    = g_rd[1].data_fwd;
    assign q_count     = count;
    assign busy        = (count != '0);
    assign retired_cnt = retired_cnt_reg;

endmodule
